// File: rtl/ps2_key_pkg.sv
// Shared constants and types for the PS/2 key event tracker.
// Contents: scan-code bytes, game key codes, the event word layout,
// the decoder state enum and the scan-code to key-code lookups.
package ps2_key_pkg;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned WORD_W  = 16;
   localparam int unsigned CODE_W  = 3;
   localparam int unsigned KEYS    = 5;
   localparam int unsigned REL_BIT = 15;

   // Prefix bytes
   localparam logic [BYTE_W-1:0] SC_F0 = 8'hF0;
   localparam logic [BYTE_W-1:0] SC_E0 = 8'hE0;

   // Non-extended game scan codes
   localparam logic [BYTE_W-1:0] SC_1C = 8'h1C;
   localparam logic [BYTE_W-1:0] SC_23 = 8'h23;
   localparam logic [BYTE_W-1:0] SC_1D = 8'h1D;
   localparam logic [BYTE_W-1:0] SC_1B = 8'h1B;
   localparam logic [BYTE_W-1:0] SC_29 = 8'h29;

   // Extended (E0-prefixed) game scan codes
   localparam logic [BYTE_W-1:0] SC_6B = 8'h6B;
   localparam logic [BYTE_W-1:0] SC_74 = 8'h74;
   localparam logic [BYTE_W-1:0] SC_75 = 8'h75;
   localparam logic [BYTE_W-1:0] SC_72 = 8'h72;

   // Game key codes; 0 means "not a game key"
   localparam logic [CODE_W-1:0] KEY_NONE  = 3'd0;
   localparam logic [CODE_W-1:0] KEY_LEFT  = 3'd1;
   localparam logic [CODE_W-1:0] KEY_RIGHT = 3'd2;
   localparam logic [CODE_W-1:0] KEY_UP    = 3'd3;
   localparam logic [CODE_W-1:0] KEY_DOWN  = 3'd4;
   localparam logic [CODE_W-1:0] KEY_SHOOT = 3'd5;

   // Event word as seen by the CPU: bit15 release flag, bits[2:0] key code
   typedef struct packed {
      logic                            release_flag;
      logic [WORD_W-CODE_W-2:0]        zero;
      logic [CODE_W-1:0]               code;
   } key_event_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } dec_state_t;

   // Key code for a byte that arrived without an E0 prefix
   function automatic logic [CODE_W-1:0] norm_code(input logic [BYTE_W-1:0] b);
      case (b)
         SC_1C:   norm_code = KEY_LEFT;
         SC_23:   norm_code = KEY_RIGHT;
         SC_1D:   norm_code = KEY_UP;
         SC_1B:   norm_code = KEY_DOWN;
         SC_29:   norm_code = KEY_SHOOT;
         default: norm_code = KEY_NONE;
      endcase
   endfunction

   // Key code for a byte that followed an E0 prefix (E0 29 is not a game key)
   function automatic logic [CODE_W-1:0] ext_code(input logic [BYTE_W-1:0] b);
      case (b)
         SC_6B:   ext_code = KEY_LEFT;
         SC_74:   ext_code = KEY_RIGHT;
         SC_75:   ext_code = KEY_UP;
         SC_72:   ext_code = KEY_DOWN;
         default: ext_code = KEY_NONE;
      endcase
   endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word fall-through event FIFO: storage, pointers and count only.
// Ports: clk, reset (sync, active-high), push/din write side,
// pop/dout read side (dout is 0 when empty), empty, full.
// A pop while empty is ignored; a push while full only lands if a pop
// happens in the same cycle.
module key_event_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic [15:0] din,
   input  logic        pop,
   output logic [15:0] dout,
   output logic        empty,
   output logic        full
);

   localparam int unsigned CW = AW + 1;

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? 16'h0000 : mem[rd_ptr];

   // Pointers and occupancy; pointers wrap naturally at 2**AW
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage is not reset; empty gates what the reader sees
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ps2_key_event_tracker.sv
// Scan-code decoder, held-key bitmap and event queue for the game keys.
// Ports: clk, reset (sync, active-high); byte_valid/byte_data from the
// PS/2 receiver; rd_en pops the head event; clr_overflow clears overflow.
// Outputs: keyboard_input (head event, 0 when empty), event_valid,
// key_state (bit0 left .. bit4 shoot), overflow (sticky drop flag).
module ps2_key_event_tracker
   import ps2_key_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   input  logic              rd_en,
   input  logic              clr_overflow,
   output logic [WORD_W-1:0] keyboard_input,
   output logic              event_valid,
   output logic [KEYS-1:0]   key_state,
   output logic              overflow
);

   dec_state_t        state;
   logic [CODE_W-1:0] code_c;
   logic              press_c;
   logic              release_c;
   logic [KEYS-1:0]   key_mask_c;
   logic              press_new_c;
   logic              release_new_c;
   logic              push_c;
   logic              drop_c;
   logic              fifo_empty;
   logic              fifo_full;
   key_event_t        event_c;

   // Classify the incoming byte against the current prefix state
   always_comb begin
      code_c    = KEY_NONE;
      press_c   = 1'b0;
      release_c = 1'b0;
      if (byte_valid) begin
         case (state)
            ST_IDLE: begin
               if (byte_data != SC_F0 && byte_data != SC_E0) begin
                  code_c  = norm_code(byte_data);
                  press_c = (code_c != KEY_NONE);
               end
            end
            ST_EXT: begin
               if (byte_data != SC_F0) begin
                  code_c  = ext_code(byte_data);
                  press_c = (code_c != KEY_NONE);
               end
            end
            ST_BRK: begin
               code_c    = norm_code(byte_data);
               release_c = (code_c != KEY_NONE);
            end
            ST_EXT_BRK: begin
               code_c    = ext_code(byte_data);
               release_c = (code_c != KEY_NONE);
            end
            default: ;
         endcase
      end
   end

   // Only edges of the held bitmap produce events; typematic repeats and
   // releases of unheld keys are swallowed here
   always_comb begin
      key_mask_c = '0;
      if (code_c != KEY_NONE) key_mask_c = KEYS'(1) << (code_c - CODE_W'(1));
   end

   assign press_new_c   = press_c   && ((key_state & key_mask_c) == '0);
   assign release_new_c = release_c && ((key_state & key_mask_c) != '0);
   assign push_c        = press_new_c || release_new_c;
   assign drop_c        = push_c && fifo_full && !rd_en;

   always_comb begin
      event_c              = '0;
      event_c.release_flag = release_new_c;
      event_c.code         = code_c;
   end

   // Decoder FSM, held-key bitmap and sticky overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         key_state <= '0;
         overflow  <= 1'b0;
      end else begin
         if (byte_valid) begin
            case (state)
               ST_IDLE: begin
                  if (byte_data == SC_F0)      state <= ST_BRK;
                  else if (byte_data == SC_E0) state <= ST_EXT;
               end
               ST_EXT: begin
                  if (byte_data == SC_F0) state <= ST_EXT_BRK;
                  else                    state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
         if (press_new_c)   key_state <= key_state | key_mask_c;
         if (release_new_c) key_state <= key_state & ~key_mask_c;
         // A drop in the same cycle as a clear leaves the flag set
         if (drop_c)            overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

   key_event_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_c),
      .din   (event_c),
      .pop   (rd_en),
      .dout  (keyboard_input),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign event_valid = !fifo_empty;

endmodule

// File: doc/ps2_key_event_tracker.md
Name: ps2_key_event_tracker

Overview:
- Downstream of the PS/2 frame receiver. Consumes received scan-code bytes, one-cycle strobe per byte, already in the clk domain.
- Decodes make, break (F0) and extended (E0) prefix sequences for the game keys.
- Maintains a held-key bitmap and queues press/release events in a small FIFO.
- The CPU reads the FIFO through a memory-mapped 16-bit word.

Parameters:
- DEPTH, 8, event FIFO entries (power of two, 2..32)
- AW, 3, FIFO pointer width, log2(DEPTH)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- byte_valid  input  1  one-cycle strobe: byte_data holds a new scan byte
- byte_data  input  8  scan byte
- rd_en  input  1  CPU pop strobe for the head event
- clr_overflow  input  1  clears the overflow flag
- keyboard_input  output  16  head event word; 0 when the FIFO is empty
- event_valid  output  1  FIFO not empty
- key_state  output  5  held bitmap: bit0 left, bit1 right, bit2 up, bit3 down, bit4 shoot
- overflow  output  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: all outputs 0, FIFO empty, decoder in IDLE.
  - A reset asserted mid-prefix-sequence discards the partial sequence.
- Key codes (game encoding):
  - 1 = left: 1C, or E0 6B
  - 2 = right: 23, or E0 74
  - 3 = up: 1D, or E0 75
  - 4 = down: 1B, or E0 72
  - 5 = shoot: 29
  - E0 29 is not a game key.
- Event word:
  - bits[2:0] = key code
  - bit15 = 1 for release, 0 for press
  - all other bits 0
- Decoder FSM, which advances only on byte_valid:
  - IDLE:
    - F0 -> BRK
    - E0 -> EXT
    - non-extended game code -> press handling, stay in IDLE
    - any other byte (AA, FA, EE, unknown) -> ignored
  - EXT:
    - F0 -> EXT_BRK
    - extended game code -> press handling, then IDLE
    - else -> IDLE
  - BRK: non-extended game code -> release handling; any byte -> IDLE
  - EXT_BRK: extended game code -> release handling; any byte -> IDLE
- Press handling:
  - If the key bit is already set (typematic repeat): no event, no change.
  - Otherwise: set the bit and push a press event.
- Release handling:
  - If the key bit is clear: no event.
  - Otherwise: clear the bit and push a release event.
- Aliases (A and left-arrow) share one bit and code. The first press sets the bit; the first release clears it.
- Latency: byte_valid at cycle N -> key_state and the FIFO update at edge N+1. With the FIFO empty, keyboard_input and event_valid are valid at N+1.
- FIFO behaviour:
  - First-word fall-through. keyboard_input shows the head combinationally from storage, forced to 0 when empty.
  - rd_en while empty: ignored.
  - Push while full, no pop that cycle: event dropped, overflow set. key_state still updates.
  - Simultaneous push and pop while full: both occur, count unchanged, no overflow.
  - Simultaneous push and pop while empty: the pop is ignored, the push is stored.
  - Pointers wrap modulo DEPTH. Count is AW+1 bits.
- overflow: clr_overflow clears it. If clr_overflow and a drop occur in the same cycle, set wins.
- byte_valid is at most one per cycle. There is no backpressure to the receiver.

Decomposition:
- Package ps2_key_pkg:
  - scan constants: F0, E0, 1C, 23, 1D, 1B, 29, 6B, 74, 75, 72
  - key code constants 1..5
  - release bit index 15
  - FSM state enum: IDLE, EXT, BRK, EXT_BRK
- Sub-module key_event_fifo:
  - parameters DEPTH and AW; ports push, din[15:0], pop, dout, empty, full
  - holds the storage, pointers and count only; the tracker owns overflow.

Test Plan:
- Reset, then bytes 1C; F0 1C -> events 0x0001 then 0x8001 in order; key_state 00001 -> 00000; event_valid drops after two rd_en.
- Bytes 1D 1D 1D (typematic) then F0 1D -> exactly two events (0x0003, 0x8003); key_state bit2 high only between them.
- Bytes E0 74, then E0 F0 74, then E0 29, then AA -> events 0x0002, 0x8002 only; FSM in IDLE after each sequence.
- No reads, nine distinct press/release events with DEPTH=8 -> 8 stored, overflow=1, first event at head. Next, a push with rd_en in the same cycle while full -> count stays 8, no new drop. clr_overflow -> overflow=0.
- Reset asserted after F0, then byte 29 -> treated as a press: event 0x0005, key_state bit4=1.
- rd_en on an empty FIFO plus byte_valid 23 in the same cycle -> next cycle keyboard_input=0x0002, event_valid=1.
